sched_ws: RTL and testbench
===========================

# sched_ws

Parametrised phase scheduler with memory wait-state handshake, run/halt/single-step control and execution counters, successor to the fixed four-phase scheduler. It sits beside the next-generation CPU core and drives its phase strobes. It stretches any memory-using phase until the bus reports ready, or until a timeout expires. Instruction and cycle counts are exposed for test and debug muxes.

## Interface
- NPH, 4: number of phases per instruction, 2..8; phase 0 is fetch.
- MEM_MASK, 4'b0101: bit i set means phase i may access memory (default: fetch and mem phase). Bit 0 must be set.
- TIMEOUT, 15: maximum wait cycles per phase before forced advance, 1..255.
- CNTW, 32: counter width.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = free-run; 0 = stop at the next instruction boundary.
- step  in  1  one-cycle pulse; starts exactly one instruction when halted.
- mem_use  in  1  the current instruction accesses memory in its non-zero MEM_MASK phases (decoder output; ld/st).
- mbus_ready  in  1  memory completes the current access this cycle.
- ph  out  NPH  one-hot active phase; all zero when halted.
- ph_idx  out  3  binary index of the active phase.
- ph_en  out  1  last cycle of the active phase; the core qualifies register writes with ph[i] & ph_en.
- halted  out  1  scheduler is in HALT.
- bus_err  out  1  one-cycle pulse on a timeout-forced advance.
- clk_stat  out  3  {ph[0] active, waiting, halted}.
- cyc_cnt  out  CNTW  active cycles since reset.
- inst_cnt  out  CNTW  completed instructions since reset.

## Operation
- FSM states are HALT and ACTIVE. A phase counter is 0..NPH-1. A step-mode flag and a wait counter (8 bit) complete the state.
- Reset forces HALT, phase 0, step-mode 0, wait counter 0, both counters 0. Outputs after reset: ph=0, ph_idx=0, ph_en=0, halted=1, bus_err=0, clk_stat=3'b001.
- HALT handling:
  - If run=1, the next state is ACTIVE at phase 0 with step-mode=0.
  - Else if step=1, the next state is ACTIVE at phase 0 with step-mode=1.
  - run has priority over step. A step while ACTIVE is ignored.
- need = ACTIVE & MEM_MASK[phase] & (phase==0 | mem_use).
- waiting = need & ~mbus_ready & (wait counter < TIMEOUT).
- ph_en = ACTIVE & ~waiting. The wait counter increments while waiting and clears whenever ph_en=1.
- bus_err = ph_en & need & ~mbus_ready, which is true only when the timeout is reached.
- On ph_en, when phase < NPH-1: phase increments.
- On ph_en, when phase = NPH-1:
  - inst_cnt increments.
  - If run=1 and step-mode=0, go to phase 0 and stay ACTIVE.
  - Otherwise go to HALT at phase 0.
- Deasserting run mid-instruction never truncates the instruction. Halt takes effect only at the boundary.
- cyc_cnt increments in every ACTIVE cycle, including wait cycles. Both counters wrap modulo 2^CNTW with no flag.
- Behaviour is undefined if mem_use changes within an instruction.

## Timing
- All outputs are derived from registered state plus the current mem_use and mbus_ready. ph_en, bus_err and clk_stat[1] are combinational from mbus_ready within the same cycle.
- Without waits, one instruction takes exactly NPH cycles and ph rotates 1,2,4,8,1...
- Each wait cycle lengthens its phase by one cycle. A phase lasts at most TIMEOUT+1 cycles.
- Latency from run rising in HALT to ph[0]=1 is 1 cycle. Latency from a step pulse to ph[0]=1 is 1 cycle.
- The last-phase ph_en cycle is followed by halted=1 (stop case) or by ph[0]=1 (continue case). No bubble cycle occurs between instructions in free-run.
- Reset asserted mid-phase takes effect at the next edge regardless of waiting and discards the partial instruction without incrementing inst_cnt.

## Test plan
- Free-run with default parameters, mbus_ready=1, run=1 from reset release:
  - ph sequence is 0, 1, 2, 4, 8, 1...
  - After 40 active cycles, inst_cnt=10 and cyc_cnt=40.
- Fetch wait: mbus_ready=0 for the first 3 cycles of phase 0, then 1.
  - ph[0] is held 4 cycles.
  - ph_en is 1 only on the 4th cycle.
  - clk_stat[1]=1 for 3 cycles.
  - The instruction takes 7 cycles.
- mem_use=0 with mbus_ready=0 permanently:
  - Phase 2 never waits.
  - Phase 0 times out after 15 wait cycles, with bus_err pulsed exactly once in the 16th cycle.
- Single step with run=0: one step pulse.
  - Exactly 4 active cycles follow, then halted=1.
  - inst_cnt goes from 0 to 1.
  - A second step pulse during ACTIVE is ignored.
- run dropped in phase 1: the instruction completes through phase 3, then halted=1 and ph=0. Raising run gives ph[0]=1 on the next cycle.
- NPH=6 with MEM_MASK=6'b000101: rotation period is 6 cycles. Synchronous reset asserted during a wait in phase 2 gives ph=0, halted=1 and counters 0 after one edge.

Source files
------------

// File: rtl/sched_ws.sv
// sched_ws: parametrised instruction phase scheduler for the CPU core.
// Rotates a one-hot phase strobe, stretches memory phases until the bus is
// ready (bounded by TIMEOUT), and supports run / halt / single-step control.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   run             - 1 = free-run, 0 = stop at next instruction boundary
//   step            - one-cycle pulse, starts one instruction when halted
//   mem_use         - current instruction uses memory in its data phases
//   mbus_ready      - memory completes the current access this cycle
//   ph / ph_idx     - one-hot / binary active phase (ph is 0 when halted)
//   ph_en           - last cycle of the active phase
//   halted          - scheduler is halted
//   bus_err         - pulse on a timeout-forced phase advance
//   clk_stat        - {fetch phase active, waiting, halted}
//   cyc_cnt         - active cycles since reset (wraps)
//   inst_cnt        - completed instructions since reset (wraps)
module sched_ws #(
  parameter int unsigned      NPH      = 4,
  parameter logic [NPH-1:0]   MEM_MASK = NPH'(4'b0101),
  parameter int unsigned      TIMEOUT  = 15,
  parameter int unsigned      CNTW     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            mem_use,
  input  logic            mbus_ready,
  output logic [NPH-1:0]  ph,
  output logic [2:0]      ph_idx,
  output logic            ph_en,
  output logic            halted,
  output logic            bus_err,
  output logic [2:0]      clk_stat,
  output logic [CNTW-1:0] cyc_cnt,
  output logic [CNTW-1:0] inst_cnt
);

  localparam logic [7:0] MASK8 = 8'(MEM_MASK);
  localparam logic [7:0] TO8   = 8'(TIMEOUT);
  localparam logic [2:0] LAST  = 3'(NPH - 1);

  typedef enum logic {S_HALT, S_ACTIVE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_phase;
  logic [2:0]      w_phase_nxt;
  logic            r_step_mode;
  logic            w_step_mode_nxt;
  logic [7:0]      r_wait;
  logic [7:0]      w_wait_nxt;
  logic [CNTW-1:0] r_cyc_cnt;
  logic [CNTW-1:0] r_inst_cnt;

  logic w_active;
  logic w_need;
  logic w_waiting;
  logic w_ph_en;
  logic w_last;

  // Phase stretch decision: fetch always needs the bus, other masked phases
  // only for ld/st instructions; the wait counter bounds the stretch.
  assign w_active  = (r_state == S_ACTIVE);
  assign w_need    = w_active & MASK8[r_phase] & ((r_phase == 3'd0) | mem_use);
  assign w_waiting = w_need & ~mbus_ready & (r_wait < TO8);
  assign w_ph_en   = w_active & ~w_waiting;
  assign w_last    = (r_phase == LAST);

  assign ph       = w_active ? (NPH'(1) << r_phase) : '0;
  assign ph_idx   = r_phase;
  assign ph_en    = w_ph_en;
  assign halted   = ~w_active;
  assign bus_err  = w_ph_en & w_need & ~mbus_ready;
  assign clk_stat = {w_active & (r_phase == 3'd0), w_waiting, ~w_active};
  assign cyc_cnt  = r_cyc_cnt;
  assign inst_cnt = r_inst_cnt;

  // Next-state: HALT leaves on run (priority) or step; ACTIVE only stops at
  // the end of the last phase so an instruction is never truncated.
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_step_mode_nxt = r_step_mode;
    w_wait_nxt      = r_wait;
    case (r_state)
      S_HALT: begin
        w_phase_nxt = 3'd0;
        if (run) begin
          w_state_nxt     = S_ACTIVE;
          w_step_mode_nxt = 1'b0;
        end else if (step) begin
          w_state_nxt     = S_ACTIVE;
          w_step_mode_nxt = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_waiting) begin
          w_wait_nxt = r_wait + 8'd1;
        end
        if (w_ph_en) begin
          w_wait_nxt = 8'd0;
          if (!w_last) begin
            w_phase_nxt = r_phase + 3'd1;
          end else begin
            w_phase_nxt = 3'd0;
            if (!(run && !r_step_mode)) begin
              w_state_nxt = S_HALT;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_HALT;
        w_phase_nxt = 3'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HALT;
      r_phase     <= 3'd0;
      r_step_mode <= 1'b0;
      r_wait      <= 8'd0;
      r_cyc_cnt   <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_step_mode <= w_step_mode_nxt;
      r_wait      <= w_wait_nxt;
      if (w_active) begin
        r_cyc_cnt <= r_cyc_cnt + CNTW'(1);
      end
      if (w_ph_en && w_last) begin
        r_inst_cnt <= r_inst_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sched_ws.sv
// tb_sched_ws: directed, table-driven bench for sched_ws (default 4-phase
// instance) plus a 6-phase instance for rotation and mid-wait reset.
module tb_sched_ws;

  logic        clk;
  logic        reset, run, step, mem_use, mbus_ready;
  logic [3:0]  ph;
  logic [2:0]  ph_idx;
  logic        ph_en, halted, bus_err;
  logic [2:0]  clk_stat;
  logic [31:0] cyc_cnt, inst_cnt;

  logic        b_reset, b_run, b_step, b_mem_use, b_mbus_ready;
  logic [5:0]  b_ph;
  logic [2:0]  b_ph_idx;
  logic        b_ph_en, b_halted, b_bus_err;
  logic [2:0]  b_clk_stat;
  logic [31:0] b_cyc_cnt, b_inst_cnt;

  int n_cmp = 0;
  int n_err = 0;

  sched_ws dut_a (
    .clk(clk), .reset(reset), .run(run), .step(step), .mem_use(mem_use),
    .mbus_ready(mbus_ready), .ph(ph), .ph_idx(ph_idx), .ph_en(ph_en),
    .halted(halted), .bus_err(bus_err), .clk_stat(clk_stat),
    .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
  );

  sched_ws #(.NPH(6), .MEM_MASK(6'b000101)) dut_b (
    .clk(clk), .reset(b_reset), .run(b_run), .step(b_step), .mem_use(b_mem_use),
    .mbus_ready(b_mbus_ready), .ph(b_ph), .ph_idx(b_ph_idx), .ph_en(b_ph_en),
    .halted(b_halted), .bus_err(b_bus_err), .clk_stat(b_clk_stat),
    .cyc_cnt(b_cyc_cnt), .inst_cnt(b_inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       run, step, mu, rdy;
    logic [3:0] ph;
    logic       en, hlt, berr;
    logic [2:0] stat;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic reset_a();
    reset = 1'b1; run = 1'b0; step = 1'b0; mem_use = 1'b0; mbus_ready = 1'b1;
    nxt(); nxt();
    smp();
    chk("rst_ph", 32'(ph), 32'd0);
    chk("rst_ph_idx", 32'(ph_idx), 32'd0);
    chk("rst_ph_en", 32'(ph_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_clk_stat", 32'(clk_stat), 32'b001);
    chk("rst_cyc", cyc_cnt, 32'd0);
    chk("rst_inst", inst_cnt, 32'd0);
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    int berr_seen;
    b_reset = 1'b1; b_run = 1'b0; b_step = 1'b0; b_mem_use = 1'b0; b_mbus_ready = 1'b1;

    //            run step mu rdy  ph  en hlt berr stat
    vt[0]  = '{1'b1,1'b0,1'b0,1'b1,4'h0,1'b0,1'b1,1'b0,3'b001};
    vt[1]  = '{1'b1,1'b0,1'b0,1'b1,4'h1,1'b1,1'b0,1'b0,3'b100};
    vt[2]  = '{1'b1,1'b0,1'b0,1'b1,4'h2,1'b1,1'b0,1'b0,3'b000};
    vt[3]  = '{1'b1,1'b0,1'b0,1'b1,4'h4,1'b1,1'b0,1'b0,3'b000};
    vt[4]  = '{1'b1,1'b0,1'b0,1'b1,4'h8,1'b1,1'b0,1'b0,3'b000};
    vt[5]  = '{1'b1,1'b0,1'b0,1'b0,4'h1,1'b0,1'b0,1'b0,3'b110};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b0,4'h1,1'b0,1'b0,1'b0,3'b110};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,4'h1,1'b0,1'b0,1'b0,3'b110};
    vt[8]  = '{1'b1,1'b0,1'b0,1'b1,4'h1,1'b1,1'b0,1'b0,3'b100};
    vt[9]  = '{1'b1,1'b0,1'b0,1'b1,4'h2,1'b1,1'b0,1'b0,3'b000};
    vt[10] = '{1'b1,1'b0,1'b0,1'b1,4'h4,1'b1,1'b0,1'b0,3'b000};
    vt[11] = '{1'b0,1'b0,1'b0,1'b1,4'h8,1'b1,1'b0,1'b0,3'b000};
    vt[12] = '{1'b1,1'b0,1'b1,1'b1,4'h0,1'b0,1'b1,1'b0,3'b001};
    vt[13] = '{1'b1,1'b0,1'b1,1'b1,4'h1,1'b1,1'b0,1'b0,3'b100};
    vt[14] = '{1'b1,1'b0,1'b1,1'b1,4'h2,1'b1,1'b0,1'b0,3'b000};
    vt[15] = '{1'b1,1'b0,1'b1,1'b0,4'h4,1'b0,1'b0,1'b0,3'b010};
    vt[16] = '{1'b1,1'b0,1'b1,1'b1,4'h4,1'b1,1'b0,1'b0,3'b000};
    vt[17] = '{1'b0,1'b0,1'b1,1'b1,4'h8,1'b1,1'b0,1'b0,3'b000};
    vt[18] = '{1'b0,1'b0,1'b0,1'b1,4'h0,1'b0,1'b1,1'b0,3'b001};

    // Table: free-run, fetch wait of 3 cycles, data-phase wait, stop at boundary.
    reset_a();
    for (int i = 0; i < 19; i++) begin
      run = vt[i].run; step = vt[i].step; mem_use = vt[i].mu; mbus_ready = vt[i].rdy;
      smp();
      chk($sformatf("vec%0d_ph", i), 32'(ph), 32'(vt[i].ph));
      chk($sformatf("vec%0d_ph_en", i), 32'(ph_en), 32'(vt[i].en));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vt[i].hlt));
      chk($sformatf("vec%0d_bus_err", i), 32'(bus_err), 32'(vt[i].berr));
      chk($sformatf("vec%0d_clk_stat", i), 32'(clk_stat), 32'(vt[i].stat));
      nxt();
    end
    smp();
    chk("tbl_cyc", cyc_cnt, 32'd16);
    chk("tbl_inst", inst_cnt, 32'd3);
    nxt();

    // Free-run 40 active cycles.
    reset_a();
    run = 1'b1; mbus_ready = 1'b1;
    smp();
    chk("fr_halt_cycle", 32'(ph), 32'd0);
    nxt();
    for (int k = 0; k < 40; k++) begin
      smp();
      chk($sformatf("fr_ph%0d", k), 32'(ph), 32'(4'b0001 << (k % 4)));
      nxt();
    end
    smp();
    chk("fr_cyc40", cyc_cnt, 32'd40);
    chk("fr_inst10", inst_cnt, 32'd10);
    nxt();

    // mem_use=0, bus never ready: fetch times out, phase 2 never waits.
    reset_a();
    run = 1'b1; mem_use = 1'b0; mbus_ready = 1'b0;
    berr_seen = 0;
    nxt();
    for (int k = 0; k < 16; k++) begin
      smp();
      chk($sformatf("to_ph0_%0d", k), 32'(ph), 32'd1);
      chk($sformatf("to_en_%0d", k), 32'(ph_en), 32'(k == 15));
      chk($sformatf("to_berr_%0d", k), 32'(bus_err), 32'(k == 15));
      chk($sformatf("to_wait_%0d", k), 32'(clk_stat[1]), 32'(k < 15));
      berr_seen += int'(bus_err);
      nxt();
    end
    run = 1'b0;
    for (int k = 1; k < 4; k++) begin
      smp();
      chk($sformatf("to_ph%0d", k), 32'(ph), 32'(4'b0001 << k));
      chk($sformatf("to_ph%0d_en", k), 32'(ph_en), 32'd1);
      if (k == 2) chk("to_ph_idx2", 32'(ph_idx), 32'd2);
      berr_seen += int'(bus_err);
      nxt();
    end
    chk("to_berr_count", 32'(berr_seen), 32'd1);

    // Single step; a second step while active is ignored.
    reset_a();
    run = 1'b0; step = 1'b1; mbus_ready = 1'b1;
    smp();
    chk("st_halt_cycle", 32'(halted), 32'd1);
    nxt();
    step = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk($sformatf("st_active%0d", k), 32'(halted), 32'd0);
      chk($sformatf("st_ph%0d", k), 32'(ph), 32'(4'b0001 << k));
      nxt();
      step = (k == 0);
    end
    step = 1'b0;
    smp();
    chk("st_halted", 32'(halted), 32'd1);
    chk("st_inst", inst_cnt, 32'd1);
    chk("st_cyc", cyc_cnt, 32'd4);
    nxt();
    smp();
    chk("st_still_halted", 32'(halted), 32'd1);
    chk("st_still_ph", 32'(ph), 32'd0);
    nxt();

    // run dropped in phase 1 completes the instruction, then restart.
    reset_a();
    run = 1'b1;
    nxt();
    smp();
    chk("rd_ph0", 32'(ph), 32'd1);
    nxt();
    run = 1'b0;
    smp();
    chk("rd_ph1", 32'(ph), 32'd2);
    nxt();
    smp();
    chk("rd_ph2", 32'(ph), 32'd4);
    nxt();
    smp();
    chk("rd_ph3", 32'(ph), 32'd8);
    chk("rd_ph3_en", 32'(ph_en), 32'd1);
    nxt();
    run = 1'b1;
    smp();
    chk("rd_halted", 32'(halted), 32'd1);
    chk("rd_ph_zero", 32'(ph), 32'd0);
    nxt();
    smp();
    chk("rd_restart", 32'(ph), 32'd1);
    nxt();
    run = 1'b0;

    // NPH=6: rotation period and reset during a phase-2 wait.
    b_reset = 1'b0; b_run = 1'b1; b_mem_use = 1'b1; b_mbus_ready = 1'b1;
    smp();
    chk("b_halt_cycle", 32'(b_halted), 32'd1);
    nxt();
    for (int k = 0; k < 7; k++) begin
      smp();
      chk($sformatf("b_ph%0d", k), 32'(b_ph), 32'(6'b000001 << (k % 6)));
      nxt();
    end
    smp();
    chk("b_ph1_again", 32'(b_ph), 32'd2);
    nxt();
    b_mbus_ready = 1'b0;
    smp();
    chk("b_wait_ph", 32'(b_ph), 32'd4);
    chk("b_wait_stat", 32'(b_clk_stat), 32'b010);
    nxt();
    b_reset = 1'b1;
    smp();
    chk("b_wait2", 32'(b_clk_stat[1]), 32'd1);
    chk("b_pre_cyc", b_cyc_cnt, 32'd9);
    chk("b_pre_inst", b_inst_cnt, 32'd1);
    nxt();
    smp();
    chk("b_rst_ph", 32'(b_ph), 32'd0);
    chk("b_rst_halted", 32'(b_halted), 32'd1);
    chk("b_rst_cyc", b_cyc_cnt, 32'd0);
    chk("b_rst_inst", b_inst_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
